// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU codes,
// FSM state type and the decoded control word.
package cu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b0011;
  localparam logic [3:0] OP_MUL2  = 4'b0100;
  localparam logic [3:0] OP_DIV2  = 4'b0101;
  localparam logic [3:0] OP_CLR   = 4'b0110;
  localparam logic [3:0] OP_RST   = 4'b0111;
  localparam logic [3:0] OP_MOV   = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_OUT   = 4'b1010;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_JZ    = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SHL  = 4'b0010;
  localparam logic [3:0] ALU_SHR  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b0100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic load;
    logic reg_clr;
    logic reg_clr_all;
    logic mb_select;
    logic mem_read;
    logic mem_write;
    logic mem_select;
    logic load_pc;
    logic halt;
    logic zero_addr_a;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational opcode decoder: opcode plus zero flag -> control word and ALU code.
module cu_decoder
  import cu_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 4
) (
  input  logic [OPW-1:0]  i_opcode,
  input  logic            i_zero_flag,
  output ctrl_t           o_ctrl,
  output logic [ALUW-1:0] o_alu_opcode
);

  logic [3:0] w_alu;
  logic       w_alu_used;

  always_comb begin
    o_ctrl     = '0;
    w_alu      = ALU_ADD;
    w_alu_used = 1'b0;
    case (i_opcode)
      OPW'(OP_ADD):   begin w_alu_used = 1'b1; o_ctrl.mb_select = 1'b1; o_ctrl.load = 1'b1; end
      OPW'(OP_SUB):   begin w_alu_used = 1'b1; w_alu = ALU_SUB; o_ctrl.mb_select = 1'b1; o_ctrl.load = 1'b1; end
      OPW'(OP_ADDI):  begin w_alu_used = 1'b1; o_ctrl.load = 1'b1; end
      OPW'(OP_SUBI):  begin w_alu_used = 1'b1; w_alu = ALU_SUB; o_ctrl.load = 1'b1; end
      OPW'(OP_MUL2):  begin w_alu_used = 1'b1; w_alu = ALU_SHL; o_ctrl.load = 1'b1; end
      OPW'(OP_DIV2):  begin w_alu_used = 1'b1; w_alu = ALU_SHR; o_ctrl.load = 1'b1; end
      OPW'(OP_CLR):   o_ctrl.reg_clr = 1'b1;
      OPW'(OP_RST):   o_ctrl.reg_clr_all = 1'b1;
      OPW'(OP_MOV):   begin w_alu_used = 1'b1; w_alu = ALU_PASS; o_ctrl.mb_select = 1'b1; o_ctrl.load = 1'b1; end
      OPW'(OP_JMP):   o_ctrl.load_pc = 1'b1;
      OPW'(OP_JZ):    o_ctrl.load_pc = i_zero_flag;
      OPW'(OP_OUT):   o_ctrl.mem_read = 1'b1;
      OPW'(OP_LOAD):  begin o_ctrl.zero_addr_a = 1'b1; o_ctrl.mem_read = 1'b1; o_ctrl.mem_select = 1'b1; end
      OPW'(OP_STORE): begin o_ctrl.zero_addr_a = 1'b1; o_ctrl.mem_write = 1'b1; end
      OPW'(OP_HALT):  o_ctrl.halt = 1'b1;
      default:        ; // NOP and any unlisted code: no strobes
    endcase
  end

  assign o_alu_opcode = w_alu_used ? ALUW'(w_alu) : {ALUW{1'b1}};

endmodule

// File: rtl/multicycle_control_unit.sv
// Handshaked multicycle control unit: FSM, registered control outputs and
// optional memory-wait timeout (enabled by defining CU_MEM_TIMEOUT_EN).
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned REGW    = 3,
  parameter int unsigned PCW     = 8,
  parameter int unsigned ALUW    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPW+2*REGW-1:0]   i_instruction,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  input  logic                    i_zero_flag,
  output logic [REGW-1:0]         o_addr_a,
  output logic [REGW-1:0]         o_addr_b,
  output logic                    o_load,
  output logic                    o_reg_clr,
  output logic                    o_reg_clr_all,
  output logic                    o_mb_select,
  output logic [ALUW-1:0]         o_alu_opcode,
  output logic                    o_mem_read,
  output logic                    o_mem_write,
  output logic [2*REGW-1:0]       o_mem_addr,
  output logic                    o_mem_select,
  input  logic                    i_mem_ready,
  output logic                    o_load_pc,
  output logic [PCW-1:0]          o_pc_value,
  output logic                    o_halted,
  output logic                    o_mem_err
);

  localparam int unsigned IW = OPW + 2*REGW;

  if (PCW < 2*REGW || OPW < 4 || TIMEOUT == 0) begin : g_param_check
    $error("multicycle_control_unit: illegal parameter combination");
  end

  logic [OPW-1:0]    w_opcode;
  logic [2*REGW-1:0] w_operand;
  ctrl_t             w_ctrl;
  logic [ALUW-1:0]   w_alu;

  assign w_opcode  = i_instruction[IW-1 -: OPW];
  assign w_operand = i_instruction[2*REGW-1:0];

  cu_decoder #(.OPW(OPW), .ALUW(ALUW)) u_decoder (
    .i_opcode     (w_opcode),
    .i_zero_flag  (i_zero_flag),
    .o_ctrl       (w_ctrl),
    .o_alu_opcode (w_alu)
  );

  state_t            r_state, w_state_nxt;
  logic [REGW-1:0]   r_addr_a, r_addr_b, w_addr_a_nxt, w_addr_b_nxt;
  logic              r_load, r_reg_clr, r_reg_clr_all, r_load_pc;
  logic              w_load_nxt, w_reg_clr_nxt, w_reg_clr_all_nxt, w_load_pc_nxt;
  logic              r_mb_select, r_mem_select, w_mb_select_nxt, w_mem_select_nxt;
  logic              r_mem_read, r_mem_write, w_mem_read_nxt, w_mem_write_nxt;
  logic [ALUW-1:0]   r_alu_opcode, w_alu_opcode_nxt;
  logic [2*REGW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [PCW-1:0]    r_pc_value, w_pc_value_nxt;
  logic              r_halted, w_halted_nxt;

`ifdef CU_MEM_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic            r_mem_err, w_mem_err_nxt;
`endif

  // Next state and next registered outputs; pulses default low, fields hold
  always_comb begin
    w_state_nxt        = r_state;
    w_load_nxt         = 1'b0;
    w_reg_clr_nxt      = 1'b0;
    w_reg_clr_all_nxt  = 1'b0;
    w_load_pc_nxt      = 1'b0;
    w_mem_read_nxt     = r_mem_read;
    w_mem_write_nxt    = r_mem_write;
    w_addr_a_nxt       = r_addr_a;
    w_addr_b_nxt       = r_addr_b;
    w_mb_select_nxt    = r_mb_select;
    w_mem_select_nxt   = r_mem_select;
    w_alu_opcode_nxt   = r_alu_opcode;
    w_mem_addr_nxt     = r_mem_addr;
    w_pc_value_nxt     = r_pc_value;
    w_halted_nxt       = r_halted;
`ifdef CU_MEM_TIMEOUT_EN
    w_wait_cnt_nxt     = '0;
    w_mem_err_nxt      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_instr_valid) begin
          w_addr_a_nxt     = w_ctrl.zero_addr_a ? '0 : w_operand[2*REGW-1:REGW];
          w_addr_b_nxt     = w_operand[REGW-1:0];
          w_mb_select_nxt  = w_ctrl.mb_select;
          w_mem_select_nxt = w_ctrl.mem_select;
          w_alu_opcode_nxt = w_alu;
          w_mem_addr_nxt   = w_operand;
          w_pc_value_nxt   = PCW'(w_operand);
          if (w_ctrl.halt) begin
            w_state_nxt  = ST_HALT;
            w_halted_nxt = 1'b1;
          end else if (w_ctrl.mem_read || w_ctrl.mem_write) begin
            w_state_nxt     = ST_MEM;
            w_mem_read_nxt  = w_ctrl.mem_read;
            w_mem_write_nxt = w_ctrl.mem_write;
          end else begin
            w_state_nxt       = ST_EXEC;
            w_load_nxt        = w_ctrl.load;
            w_reg_clr_nxt     = w_ctrl.reg_clr;
            w_reg_clr_all_nxt = w_ctrl.reg_clr_all;
            w_load_pc_nxt     = w_ctrl.load_pc;
          end
        end
      end
      ST_EXEC, ST_WB: w_state_nxt = ST_IDLE;
      ST_MEM: begin
        // mem_select is only set by LOAD, which is the one access needing write-back
        if (i_mem_ready) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = r_mem_select ? ST_WB : ST_IDLE;
          w_load_nxt      = r_mem_select;
        end
`ifdef CU_MEM_TIMEOUT_EN
        else if (r_wait_cnt == CNTW'(TIMEOUT - 1)) begin
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_mem_err_nxt   = 1'b1;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNTW'(1);
        end
`endif
      end
      ST_HALT: ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load        <= 1'b0;
      r_reg_clr     <= 1'b0;
      r_reg_clr_all <= 1'b0;
      r_load_pc     <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_addr_a      <= '0;
      r_addr_b      <= '0;
      r_mb_select   <= 1'b0;
      r_mem_select  <= 1'b0;
      r_alu_opcode  <= '0;
      r_mem_addr    <= '0;
      r_pc_value    <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_load        <= w_load_nxt;
      r_reg_clr     <= w_reg_clr_nxt;
      r_reg_clr_all <= w_reg_clr_all_nxt;
      r_load_pc     <= w_load_pc_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_addr_a      <= w_addr_a_nxt;
      r_addr_b      <= w_addr_b_nxt;
      r_mb_select   <= w_mb_select_nxt;
      r_mem_select  <= w_mem_select_nxt;
      r_alu_opcode  <= w_alu_opcode_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_pc_value    <= w_pc_value_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

`ifdef CU_MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end
  assign o_mem_err = r_mem_err;
`else
  assign o_mem_err = 1'b0;
`endif

  assign o_instr_ready = (r_state == ST_IDLE);
  assign o_addr_a      = r_addr_a;
  assign o_addr_b      = r_addr_b;
  assign o_load        = r_load;
  assign o_reg_clr     = r_reg_clr;
  assign o_reg_clr_all = r_reg_clr_all;
  assign o_mb_select   = r_mb_select;
  assign o_alu_opcode  = r_alu_opcode;
  assign o_mem_read    = r_mem_read;
  assign o_mem_write   = r_mem_write;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_select  = r_mem_select;
  assign o_load_pc     = r_load_pc;
  assign o_pc_value    = r_pc_value;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus
// randomized traffic compared every cycle against an instruction-level model.
module tb_multicycle_control_unit;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] i_instruction;
  logic       i_instr_valid, i_zero_flag, i_mem_ready;
  logic       o_instr_ready, o_load, o_reg_clr, o_reg_clr_all, o_mb_select;
  logic       o_mem_read, o_mem_write, o_mem_select, o_load_pc, o_halted, o_mem_err;
  logic [2:0] o_addr_a, o_addr_b;
  logic [3:0] o_alu_opcode;
  logic [5:0] o_mem_addr;
  logic [7:0] o_pc_value;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPW(4), .REGW(3), .PCW(8), .ALUW(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_instruction(i_instruction), .i_instr_valid(i_instr_valid),
    .o_instr_ready(o_instr_ready), .i_zero_flag(i_zero_flag),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b), .o_load(o_load),
    .o_reg_clr(o_reg_clr), .o_reg_clr_all(o_reg_clr_all), .o_mb_select(o_mb_select),
    .o_alu_opcode(o_alu_opcode), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_select(o_mem_select), .i_mem_ready(i_mem_ready),
    .o_load_pc(o_load_pc), .o_pc_value(o_pc_value), .o_halted(o_halted),
    .o_mem_err(o_mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Instruction semantics from the opcode table
  typedef struct packed {
    logic [3:0] alu;
    logic [2:0] a;
    logic [2:0] b;
    logic mb, ms, load, clr, clr_all, load_pc, rd, wr, halt;
  } dec_t;

  function automatic dec_t decode(input logic [9:0] ins, input logic zf);
    dec_t d;
    d     = '0;
    d.alu = 4'hF;
    d.a   = ins[5:3];
    d.b   = ins[2:0];
    case (ins[9:6])
      4'd0:  begin d.alu = 4'd0; d.mb = 1; d.load = 1; end
      4'd1:  begin d.alu = 4'd1; d.mb = 1; d.load = 1; end
      4'd2:  begin d.alu = 4'd0; d.load = 1; end
      4'd3:  begin d.alu = 4'd1; d.load = 1; end
      4'd4:  begin d.alu = 4'd2; d.load = 1; end
      4'd5:  begin d.alu = 4'd3; d.load = 1; end
      4'd6:  d.clr = 1;
      4'd7:  d.clr_all = 1;
      4'd8:  begin d.alu = 4'd4; d.mb = 1; d.load = 1; end
      4'd9:  d.load_pc = 1;
      4'd10: d.rd = 1;
      4'd11: begin d.a = 3'd0; d.rd = 1; d.ms = 1; end
      4'd12: begin d.a = 3'd0; d.wr = 1; end
      4'd13: d.load_pc = zf;
      4'd15: d.halt = 1;
      default: ;
    endcase
    return d;
  endfunction

  dec_t d;
  assign d = decode(i_instruction, i_zero_flag);

  // Model state: busy for one more cycle, waiting on memory, or halted
  logic       m_one, m_mem_wait, m_halted;
  int         m_wait;
  logic       e_load, e_reg_clr, e_reg_clr_all, e_load_pc, e_mem_read, e_mem_write;
  logic       e_mb, e_ms, e_mem_err;
  logic [3:0] e_alu;
  logic [2:0] e_addr_a, e_addr_b;
  logic [5:0] e_mem_addr;
  logic [7:0] e_pc;
  logic       e_ready;

  assign e_ready = !(m_one || m_mem_wait || m_halted);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_one <= 0; m_mem_wait <= 0; m_halted <= 0; m_wait <= 0;
      e_load <= 0; e_reg_clr <= 0; e_reg_clr_all <= 0; e_load_pc <= 0;
      e_mem_read <= 0; e_mem_write <= 0; e_mb <= 0; e_ms <= 0; e_mem_err <= 0;
      e_alu <= 0; e_addr_a <= 0; e_addr_b <= 0; e_mem_addr <= 0; e_pc <= 0;
    end else begin
      e_load <= 0; e_reg_clr <= 0; e_reg_clr_all <= 0; e_load_pc <= 0; e_mem_err <= 0;
      if (m_halted) begin
      end else if (m_mem_wait) begin
        if (i_mem_ready) begin
          e_mem_read <= 0; e_mem_write <= 0; m_mem_wait <= 0;
          if (e_ms) begin m_one <= 1; e_load <= 1; end
        end
`ifdef CU_MEM_TIMEOUT_EN
        else if (m_wait + 1 == TO) begin
          e_mem_read <= 0; e_mem_write <= 0; m_mem_wait <= 0; e_mem_err <= 1;
        end
`endif
        else m_wait <= m_wait + 1;
      end else if (m_one) begin
        m_one <= 0;
      end else if (i_instr_valid) begin
        e_addr_a <= d.a; e_addr_b <= d.b; e_mb <= d.mb; e_ms <= d.ms; e_alu <= d.alu;
        e_mem_addr <= i_instruction[5:0];
        e_pc <= {2'b00, i_instruction[5:0]};
        m_wait <= 0;
        if (d.halt) m_halted <= 1;
        else if (d.rd || d.wr) begin
          m_mem_wait <= 1; e_mem_read <= d.rd; e_mem_write <= d.wr;
        end else begin
          m_one <= 1; e_load <= d.load; e_reg_clr <= d.clr;
          e_reg_clr_all <= d.clr_all; e_load_pc <= d.load_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", 32'(o_instr_ready), 32'(e_ready));
      chk("load", 32'(o_load), 32'(e_load));
      chk("reg_clr", 32'(o_reg_clr), 32'(e_reg_clr));
      chk("reg_clr_all", 32'(o_reg_clr_all), 32'(e_reg_clr_all));
      chk("load_pc", 32'(o_load_pc), 32'(e_load_pc));
      chk("mem_read", 32'(o_mem_read), 32'(e_mem_read));
      chk("mem_write", 32'(o_mem_write), 32'(e_mem_write));
      chk("mem_select", 32'(o_mem_select), 32'(e_ms));
      chk("mb_select", 32'(o_mb_select), 32'(e_mb));
      chk("alu_opcode", 32'(o_alu_opcode), 32'(e_alu));
      chk("addr_a", 32'(o_addr_a), 32'(e_addr_a));
      chk("addr_b", 32'(o_addr_b), 32'(e_addr_b));
      chk("mem_addr", 32'(o_mem_addr), 32'(e_mem_addr));
      chk("pc_value", 32'(o_pc_value), 32'(e_pc));
      chk("halted", 32'(o_halted), 32'(m_halted));
      chk("mem_err", 32'(o_mem_err), 32'(e_mem_err));
    end
  end

  // Inputs change 1ns after a falling edge; returns on the next falling edge
  task automatic drive(input logic v, input logic [9:0] ins, input logic zf, input logic mr);
    #1;
    i_instr_valid = v; i_instruction = ins; i_zero_flag = zf; i_mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    #1;
    i_instr_valid = 0; i_mem_ready = 0;
    rst = 1;
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
  endtask

  localparam logic [9:0] I_ADD   = 10'b0000_001_010;
  localparam logic [9:0] I_LOAD  = 10'b1011_000101;
  localparam logic [9:0] I_JZ    = 10'b1101_010000;
  localparam logic [9:0] I_HALT  = 10'b1111_000000;
  localparam logic [9:0] I_STORE = 10'b1100_000011;

  initial begin
    int cnt_rd, cnt_ld, cnt_err;
    rst = 1; i_instr_valid = 0; i_instruction = '0; i_zero_flag = 0; i_mem_ready = 0;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    cmp_en = 1;
    chk("reset_ready", 32'(o_instr_ready), 32'd1);
    chk("reset_alu", 32'(o_alu_opcode), 32'd0);
    chk("reset_halted", 32'(o_halted), 32'd0);

    // ADD: one-cycle load pulse, ready low for one cycle
    drive(1, I_ADD, 0, 0);
    chk("add_addr_a", 32'(o_addr_a), 32'd1);
    chk("add_addr_b", 32'(o_addr_b), 32'd2);
    chk("add_mb", 32'(o_mb_select), 32'd1);
    chk("add_alu", 32'(o_alu_opcode), 32'd0);
    chk("add_load", 32'(o_load), 32'd1);
    chk("add_ready_lo", 32'(o_instr_ready), 32'd0);
    drive(0, I_ADD, 0, 0);
    chk("add_load_end", 32'(o_load), 32'd0);
    chk("add_ready_hi", 32'(o_instr_ready), 32'd1);

    // LOAD with three wait cycles
    drive(1, I_LOAD, 0, 0);
    chk("load_mem_addr", 32'(o_mem_addr), 32'd5);
    chk("load_addr_a", 32'(o_addr_a), 32'd0);
    cnt_rd = int'(o_mem_read); cnt_ld = int'(o_load);
    for (int i = 0; i < 5; i++) begin
      drive(0, 10'd0, 0, i == 3);
      cnt_rd += int'(o_mem_read);
      cnt_ld += int'(o_load);
      if (o_load) chk("wb_mem_select", 32'(o_mem_select), 32'd1);
    end
    chk("load_read_cycles", 32'(cnt_rd), 32'd4);
    chk("load_pulses", 32'(cnt_ld), 32'd1);
    chk("load_back_idle", 32'(o_instr_ready), 32'd1);

    // JZ not taken, then taken
    drive(1, I_JZ, 0, 0);
    chk("jz0_load_pc", 32'(o_load_pc), 32'd0);
    drive(0, 10'd0, 0, 0);
    drive(1, I_JZ, 1, 0);
    chk("jz1_load_pc", 32'(o_load_pc), 32'd1);
    chk("jz1_pc", 32'(o_pc_value), 32'h10);
    drive(0, 10'd0, 0, 0);
    chk("jz1_pulse_end", 32'(o_load_pc), 32'd0);

    // HALT is sticky with valid held high
    drive(1, I_HALT, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, I_ADD, 0, 1);
      chk("halt_sticky", 32'(o_halted), 32'd1);
      chk("halt_ready", 32'(o_instr_ready), 32'd0);
    end
    pulse_rst();
    chk("post_halt_halted", 32'(o_halted), 32'd0);
    chk("post_halt_ready", 32'(o_instr_ready), 32'd1);
    chk("post_halt_alu", 32'(o_alu_opcode), 32'd0);

    // STORE interrupted by reset in its second MEM cycle
    drive(1, I_STORE, 0, 0);
    drive(0, 10'd0, 0, 0);
    chk("store_write_held", 32'(o_mem_write), 32'd1);
    #1 rst = 1;
    #1 chk("store_async_drop", 32'(o_mem_write), 32'd0);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("store_no_wb", 32'(o_load), 32'd0);
    drive(1, I_ADD, 0, 0);
    chk("store_reaccept", 32'(o_load), 32'd1);
    drive(0, 10'd0, 0, 0);

`ifdef CU_MEM_TIMEOUT_EN
    drive(1, I_LOAD, 0, 0);
    cnt_rd = int'(o_mem_read); cnt_ld = 0; cnt_err = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 10'd0, 0, 0);
      cnt_rd += int'(o_mem_read); cnt_ld += int'(o_load); cnt_err += int'(o_mem_err);
    end
    chk("to_read_cycles", 32'(cnt_rd), 32'(TO));
    chk("to_err_pulses", 32'(cnt_err), 32'd1);
    chk("to_no_load", 32'(cnt_ld), 32'd0);
`endif

    // Randomized traffic; reset occasionally and whenever the model halts
    for (int i = 0; i < 3000; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        pulse_rst();
      else
        drive(1'($urandom_range(0, 9) < 6), 10'($urandom), 1'($urandom),
              1'($urandom_range(0, 9) < 4));
    end

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
